// File: rtl/regs_pkg.sv
// Shared definitions for the peripheral register-bus arbiter.
// Contents: bus width constants and the arbiter FSM state encoding.
package regs_pkg;

    localparam int REGS_AW = 8;
    localparam int REGS_DW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/regs_arbiter_if.sv
// Requester-side register bus channel, one instance per requester.
// Signals:
//   req    requester -> arbiter  transaction request, held until ack
//   addr   requester -> arbiter  register byte address
//   wdata  requester -> arbiter  write data
//   wstrb  requester -> arbiter  byte strobes, [1] high byte, [0] low byte
//   we     requester -> arbiter  write (1) / read (0)
//   ack    arbiter -> requester  one-cycle completion pulse
//   rdata  arbiter -> requester  read data, valid with ack
//   err    arbiter -> requester  timeout flag, valid with ack
// Modports: master = requester side, slave = arbiter side.
interface regs_arbiter_if;
    import regs_pkg::*;

    logic               req;
    logic [REGS_AW-1:0] addr;
    logic [REGS_DW-1:0] wdata;
    logic [1:0]         wstrb;
    logic               we;
    logic               ack;
    logic [REGS_DW-1:0] rdata;
    logic               err;

    modport master (
        output req, addr, wdata, wstrb, we,
        input  ack, rdata, err
    );

    modport slave (
        input  req, addr, wdata, wstrb, we,
        output ack, rdata, err
    );

endinterface

// File: rtl/regs_arbiter.sv
// Two-requester round-robin arbiter for the peripheral register bus.
// m0 is the CPU bus bridge, m1 the host debug bridge. Transactions are
// serialised; a register block that never acks is cut off after TIMEOUT
// cycles and the requester receives ERR_DATA with err set.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   m0, m1         requester channels (regs_arbiter_if.slave)
//   regs_req       one-cycle request pulse to the register block
//   regs_addr/wdata/wstrb/we  latched transaction fields
//   regs_ack       completion from the register block
//   regs_rdata     read data, valid with regs_ack
//   timeout_cnt    saturating count of timed-out transactions
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner
// ISSUE | regs_req pulse; timer cleared
// WAIT  | waiting for regs_ack or timer expiry
// DONE  | ack pulse to the granted requester
module regs_arbiter
    import regs_pkg::*;
#(
    parameter int                 TIMEOUT  = 16,
    parameter logic [REGS_DW-1:0] ERR_DATA = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    regs_arbiter_if.slave      m0,
    regs_arbiter_if.slave      m1,
    output logic               regs_req,
    output logic [REGS_AW-1:0] regs_addr,
    output logic [REGS_DW-1:0] regs_wdata,
    output logic [1:0]         regs_wstrb,
    output logic               regs_we,
    input  logic               regs_ack,
    input  logic [REGS_DW-1:0] regs_rdata,
    output logic [7:0]         timeout_cnt
);

    // The timer counts up from 0 in the first WAIT cycle and the expiry
    // decision is made when the incremented value would reach TIMEOUT-1,
    // which places the requester ack exactly TIMEOUT cycles after regs_req.
    localparam logic [7:0] EXPIRE = (TIMEOUT > 2) ? 8'(TIMEOUT - 2) : 8'd0;

    state_t             state, state_nxt;
    logic               grant, grant_nxt;   // 0 = m0, 1 = m1
    logic               last_grant;
    logic [7:0]         timer;
    logic               expire;
    logic [REGS_DW-1:0] done_rdata;
    logic               done_err;

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant;
        expire     = (timer >= EXPIRE);
        // ack wins over a coincident expiry
        done_rdata = regs_ack ? regs_rdata : ERR_DATA;
        done_err   = !regs_ack;
        case (state)
            IDLE: begin
                if (m0.req && m1.req) begin
                    grant_nxt = ~last_grant;
                    state_nxt = ISSUE;
                end else if (m0.req) begin
                    grant_nxt = 1'b0;
                    state_nxt = ISSUE;
                end else if (m1.req) begin
                    grant_nxt = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (regs_ack || expire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            timer       <= 8'd0;
            regs_req    <= 1'b0;
            regs_addr   <= '0;
            regs_wdata  <= '0;
            regs_wstrb  <= 2'b00;
            regs_we     <= 1'b0;
            timeout_cnt <= 8'd0;
            m0.ack      <= 1'b0;
            m0.rdata    <= '0;
            m0.err      <= 1'b0;
            m1.ack      <= 1'b0;
            m1.rdata    <= '0;
            m1.err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            regs_req <= (state_nxt == ISSUE);
            m0.ack   <= 1'b0;
            m0.err   <= 1'b0;
            m1.ack   <= 1'b0;
            m1.err   <= 1'b0;

            if (state == IDLE && state_nxt == ISSUE) begin
                grant      <= grant_nxt;
                last_grant <= grant_nxt;
                regs_addr  <= grant_nxt ? m1.addr  : m0.addr;
                regs_wdata <= grant_nxt ? m1.wdata : m0.wdata;
                regs_wstrb <= grant_nxt ? m1.wstrb : m0.wstrb;
                regs_we    <= grant_nxt ? m1.we    : m0.we;
            end

            if (state == ISSUE) timer <= 8'd0;

            if (state == WAIT) begin
                if (!regs_ack && !expire) timer <= timer + 8'd1;
                if (state_nxt == DONE) begin
                    if (grant) begin
                        m1.ack   <= 1'b1;
                        m1.rdata <= done_rdata;
                        m1.err   <= done_err;
                    end else begin
                        m0.ack   <= 1'b1;
                        m0.rdata <= done_rdata;
                        m0.err   <= done_err;
                    end
                    if (done_err && timeout_cnt != 8'hFF)
                        timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/regs_arbiter.md
Name: regs_arbiter

Overview:
- Shares the single peripheral register bus (8-bit address, 16-bit data, byte strobes) between two requesters: m0 = CPU bus bridge, m1 = host debug bridge (UART monitor).
- Sits between the requesters and the register block. Serialises transactions and uses round-robin priority.
- Guarantees completion even when the register block never acks: a timeout returns error data.

Parameters:
- TIMEOUT, 16, cycles to wait in WAIT for regs_ack before forcing completion (legal range 1..255).
- ERR_DATA, 16'hFFFF, read data returned on a timed-out transaction.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  m0 transaction request; held high until m0_ack.
- m0_addr  in  8  m0 register byte address.
- m0_wdata  in  16  m0 write data.
- m0_wstrb  in  2  m0 byte strobes: [1] = high byte, [0] = low byte.
- m0_we  in  1  m0 write (1) / read (0).
- m0_ack  out  1  one-cycle completion pulse to m0.
- m0_rdata  out  16  m0 read data; valid while m0_ack is high.
- m0_err  out  1  high together with m0_ack when the transaction timed out.
- m1_req, m1_addr, m1_wdata, m1_wstrb, m1_we, m1_ack, m1_rdata, m1_err: same as m0, for requester m1.
- regs_req  out  1  one-cycle request pulse to the register block.
- regs_addr  out  8  latched address.
- regs_wdata  out  16  latched write data.
- regs_wstrb  out  2  latched byte strobes.
- regs_we  out  1  latched write enable.
- regs_ack  in  1  completion from the register block.
- regs_rdata  in  16  read data from the register block; valid with regs_ack.
- timeout_cnt  out  8  saturating count of timed-out transactions.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = 1, so m0 wins the first contention; timer 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Neither req high: stay in IDLE.
  - One req high: grant that requester.
  - Both high: grant the requester not equal to last_grant.
  - On grant: latch the winner's addr/wdata/wstrb/we into regs_* registers, set last_grant = winner, go to ISSUE.
- ISSUE: regs_req = 1 for exactly this one cycle; clear timer; go to WAIT.
- WAIT:
  - regs_ack high: capture regs_rdata, err = 0, go to DONE.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 with no ack: rdata = ERR_DATA, err = 1, timeout_cnt increments (saturates at 255), go to DONE.
- DONE:
  - The granted requester's ack is 1 for this cycle, with rdata and err driven.
  - The non-granted requester's ack and err are 0. m*_rdata holds its last value.
  - Go to IDLE.
- regs_* address, data, strobe and we outputs are stable from ISSUE through DONE.
- Latency: req seen in IDLE at cycle 0 -> regs_req at cycle 1. With regs_ack at cycle 2, m*_ack is at cycle 3. Minimum 4 cycles per transaction, including the return to IDLE.
- Back-to-back:
  - The requester deasserts req in the cycle after its ack; IDLE samples req.
  - A requester that keeps req high through IDLE is treated as a new request.
  - Round-robin still hands the bus to the other requester if it is waiting.
- regs_ack outside WAIT (stray, or late after a timeout) is ignored; no state change.
- regs_ack in the same cycle the timer expires: the ack wins and err = 0.
- A requester dropping req after grant is a protocol violation. The transaction still completes downstream and ack still pulses.
- rst mid-transaction: immediate return to IDLE with all outputs 0. A downstream ack arriving after reset is ignored. timeout_cnt is cleared.
- No combinational path from m*_req to regs_req or from regs_ack to m*_ack; all outputs are registered.

Decomposition:
- Shared package (regs_pkg): the state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3) and the bus width constants REGS_AW = 8 and REGS_DW = 16.
- No sub-module. The two-way round-robin grant is a few lines inline; a separate arbiter module is not justified.

Test Plan:
- Single read: m0 read of addr 8'o00, regs_ack at cycle 2 with rdata 16'h1234 -> regs_req pulses at cycle 1 with addr 8'o00 and we = 0; m0_ack at cycle 3 with m0_rdata = 16'h1234 and m0_err = 0; m1_ack stays 0.
- Contention after reset: m0 and m1 request in the same cycle (m0 write of 16'h00AA to 8'o10, m1 read of 8'o60) -> m0 is served first, then m1. A second simultaneous pair -> m1 is served first (alternation).
- Byte strobes: m1 write to 8'o30 with data 16'hBEEF and wstrb 2'b10 -> regs_wdata = 16'hBEEF and regs_wstrb = 2'b10 held stable from ISSUE through DONE.
- Timeout: regs_ack never asserted, TIMEOUT = 16 -> m0_ack exactly 16 cycles after regs_req, m0_rdata = 16'hFFFF, m0_err = 1, timeout_cnt = 1. A regs_ack injected 3 cycles later is ignored.
- Ack/timeout tie: regs_ack in the expiry cycle -> err = 0, returned data is regs_rdata, timeout_cnt unchanged.
- Reset mid-op: assert rst during WAIT, then drive regs_ack the next cycle -> no m*_ack, all outputs 0, timeout_cnt = 0. The next m0 request completes normally.
